serial_width_adapter: RTL

Bidirectional width adapter between the chip's narrow serial link and the 32-bit host serial port of the simulation serial endpoint. Upstream path: packs NARROW_W-bit beats from the chip into 32-bit words presented on the endpoint's serial_out channel. Downstream path: unpacks 32-bit words from the endpoint's serial_in channel into narrow beats for the chip. Both directions are independent ready/valid pipelines in one clock domain.

---
 rtl/serial_width_adapter_if.sv | 32 +++
 rtl/serial_width_adapter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/serial_width_adapter_if.sv
// Handshake bundle for serial_width_adapter: narrow/wide channels in both directions.
// slave is the adapter's view; master is the chip/endpoint side that drives it.
interface serial_width_adapter_if #(
  parameter int NARROW_W = 4
);
  logic                narrow_in_valid;
  logic                narrow_in_ready;
  logic [NARROW_W-1:0] narrow_in_bits;
  logic                wide_out_valid;
  logic                wide_out_ready;
  logic [31:0]         wide_out_bits;
  logic                wide_in_valid;
  logic                wide_in_ready;
  logic [31:0]         wide_in_bits;
  logic                narrow_out_valid;
  logic                narrow_out_ready;
  logic [NARROW_W-1:0] narrow_out_bits;

  modport slave (
    input  narrow_in_valid, narrow_in_bits, wide_out_ready,
    input  wide_in_valid, wide_in_bits, narrow_out_ready,
    output narrow_in_ready, wide_out_valid, wide_out_bits,
    output wide_in_ready, narrow_out_valid, narrow_out_bits
  );

  modport master (
    output narrow_in_valid, narrow_in_bits, wide_out_ready,
    output wide_in_valid, wide_in_bits, narrow_out_ready,
    input  narrow_in_ready, wide_out_valid, wide_out_bits,
    input  wide_in_ready, narrow_out_valid, narrow_out_bits
  );
endinterface

// File: rtl/serial_width_adapter.sv
// Packs NARROW_W-bit beats LSB-first into 32-bit words and unpacks words back into beats; one cycle latency each way.
// Ready/valid both directions; SERIAL_WIDTH_ADAPTER_SKID_EN adds a packer output holding register (no wide_out_ready->narrow_in_ready path).
module serial_width_adapter #(
  parameter int NARROW_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  serial_width_adapter_if.slave bus,
  output logic                  idle
);
  localparam int BEATS = 32 / NARROW_W;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  generate
    if (NARROW_W != 1 && NARROW_W != 2 && NARROW_W != 4 &&
        NARROW_W != 8 && NARROW_W != 16 && NARROW_W != 32) begin : g_bad_width
      $error("serial_width_adapter: NARROW_W must be 1, 2, 4, 8, 16 or 32");
    end
  endgenerate

  typedef enum logic {PK_FILL, PK_FULL} pk_state_e;
  typedef enum logic {UP_EMPTY, UP_DRAIN} up_state_e;

  pk_state_e     pk_state, pk_next;
  logic [CW-1:0] pk_count;
  logic [31:0]   pk_word;
  logic [31:0]   pk_merged;
  logic          in_fire;
  logic          in_last;

  up_state_e     up_state, up_next;
  logic [CW-1:0] up_index;
  logic [31:0]   up_shift;
  logic          up_last;
  logic          wi_fire;
  logic          no_fire;

  assign in_fire = bus.narrow_in_valid & bus.narrow_in_ready;
  assign in_last = (pk_count == LAST);

  // Word as it would look with the current beat dropped into its slot
  always_comb begin
    pk_merged = pk_word;
    for (int k = 0; k < BEATS; k++) begin
      if (pk_count == CW'(k)) pk_merged[k*NARROW_W +: NARROW_W] = bus.narrow_in_bits;
    end
  end

`ifdef SERIAL_WIDTH_ADAPTER_SKID_EN
  logic [31:0] hold_word;
  logic        hold_valid;
  logic        hold_free;

  assign hold_free           = !hold_valid | bus.wide_out_ready;
  assign bus.narrow_in_ready = !((pk_state == PK_FULL) && hold_valid);
  assign bus.wide_out_valid  = hold_valid;
  assign bus.wide_out_bits   = hold_word;

  always_comb begin
    pk_next = pk_state;
    case (pk_state)
      PK_FILL: if (in_fire && in_last && !hold_free) pk_next = PK_FULL;
      PK_FULL: if (hold_free) pk_next = PK_FILL;
      default: pk_next = PK_FILL;
    endcase
  end

  // A finished word bypasses the pack register straight into the holding slot when it is free
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_word  <= '0;
      hold_valid <= 1'b0;
    end else if (in_fire && in_last && hold_free) begin
      hold_word  <= pk_merged;
      hold_valid <= 1'b1;
    end else if ((pk_state == PK_FULL) && hold_free) begin
      hold_word  <= pk_word;
      hold_valid <= 1'b1;
    end else if (bus.wide_out_ready) begin
      hold_valid <= 1'b0;
    end
  end

  assign idle = (pk_state == PK_FILL) && (pk_count == '0) && (up_state == UP_EMPTY) && !hold_valid;
`else
  assign bus.narrow_in_ready = (pk_state == PK_FILL) | bus.wide_out_ready;
  assign bus.wide_out_valid  = (pk_state == PK_FULL);
  assign bus.wide_out_bits   = pk_word;

  always_comb begin
    pk_next = pk_state;
    if (in_fire && in_last) pk_next = PK_FULL;
    else if ((pk_state == PK_FULL) && bus.wide_out_ready) pk_next = PK_FILL;
  end

  assign idle = (pk_state == PK_FILL) && (pk_count == '0) && (up_state == UP_EMPTY);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pk_state <= PK_FILL;
      pk_count <= '0;
      pk_word  <= '0;
    end else begin
      pk_state <= pk_next;
      if (in_fire) begin
        pk_word  <= pk_merged;
        pk_count <= in_last ? '0 : pk_count + CW'(1);
      end
    end
  end

  assign up_last              = (up_index == LAST);
  assign bus.wide_in_ready    = (up_state == UP_EMPTY) | ((up_state == UP_DRAIN) & up_last & bus.narrow_out_ready);
  assign wi_fire              = bus.wide_in_valid & bus.wide_in_ready;
  assign no_fire              = (up_state == UP_DRAIN) & bus.narrow_out_ready;
  assign bus.narrow_out_valid = (up_state == UP_DRAIN);
  assign bus.narrow_out_bits  = up_shift[NARROW_W-1:0];

  always_comb begin
    up_next = up_state;
    if (wi_fire) up_next = UP_DRAIN;
    else if (no_fire && up_last) up_next = UP_EMPTY;
  end

  // The last beat is left in place so the shift never spans the full word
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      up_state <= UP_EMPTY;
      up_index <= '0;
      up_shift <= '0;
    end else begin
      up_state <= up_next;
      if (wi_fire) begin
        up_shift <= bus.wide_in_bits;
        up_index <= '0;
      end else if (no_fire) begin
        up_index <= up_last ? '0 : up_index + CW'(1);
        if (!up_last) up_shift <= up_shift >> NARROW_W;
      end
    end
  end
endmodule
